// File: rtl/fetch_queue_pkg.sv
// Shared fetch-path types and constants for the RV32I front end.
package fetch_queue_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    // One prefetched instruction together with the byte address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Valid/ready handshake carrying fetched instructions from the fetch queue to decode.
interface fetch_queue_if #(
    parameter int XLEN = fetch_queue_pkg::XLEN
);
    logic            valid;
    logic            ready;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;

    modport master (output valid, output pc, output instr, input ready);
    modport slave  (input valid, input pc, input instr, output ready);
endinterface

// File: rtl/fetch_queue_fifo.sv
// Circular prefetch buffer: wrap-bit pointers, synchronous flush, occupancy count.
module fetch_queue_fifo #(
    parameter int  DEPTH = 4,
    parameter int  W     = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         full;

    // The extra pointer bit distinguishes full from empty without a separate flag.
    assign count = wr_ptr - rd_ptr;
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign rdata = mem[rd_ptr[AW-1:0]];

    // Pointer update: flush wins over any push/pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage; contents are only meaningful between rd_ptr and wr_ptr.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && !flush && full));

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues word reads to a
// 1-cycle instruction memory and queues the returned words for decode.
module fetch_queue #(
    parameter int              XLEN     = fetch_queue_pkg::XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   imem_req_valid,
    output logic [XLEN-1:0]        imem_addr,
    input  logic [XLEN-1:0]        imem_rdata,
    fetch_queue_if.master          dec,
    output logic [$clog2(DEPTH):0] count
);
    import fetch_queue_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   req_pc_p1;
    logic              inflight_p1;
    logic              issue;
    logic              push;
    logic              pop;
    logic              empty;
    logic [CW:0]       occupancy;
    logic [2*XLEN-1:0] head;
    logic [XLEN-1:0]   target_pc;

    // Credit counts queued entries plus the one response that may still arrive,
    // so an issued request always has a free slot waiting for it.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_p1};
    assign issue     = rst_n && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
    assign push      = inflight_p1 && !redirect_valid;
    assign pop       = !empty && dec.ready && !redirect_valid;
    assign target_pc = redirect_pc & ~XLEN'(INSTR_BYTES - 1);

    assign imem_req_valid = issue;
    assign imem_addr      = pc;

    // Head is masked while empty so decode never sees uninitialised storage.
    assign dec.valid = !empty;
    assign dec.pc    = empty ? '0 : head[2*XLEN-1:XLEN];
    assign dec.instr = empty ? '0 : head[XLEN-1:0];

    // PC and in-flight tracking; a redirect cancels any response due next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            inflight_p1 <= 1'b0;
        end else if (redirect_valid) begin
            pc          <= target_pc;
            inflight_p1 <= 1'b0;
        end else begin
            inflight_p1 <= issue;
            if (issue) pc <= pc + XLEN'(INSTR_BYTES);
        end
    end

    // Remember the address of the outstanding request to pair with its data.
    always_ff @(posedge clk) begin
        if (issue) req_pc_p1 <= pc;
    end

    // --- stage p1: memory response enters the prefetch queue ---
    fetch_queue_fifo #(
        .DEPTH (DEPTH),
        .W     (2*XLEN)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (push),
        .wdata ({req_pc_p1, imem_rdata}),
        .pop   (pop),
        .rdata (head),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a random phase,
// all compared against a queue-based reference model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst_w;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic [2:0]  count;
    logic        wreq;
    logic [31:0] waddr;
    logic [31:0] wrdata = '0;
    logic [2:0]  wcount;

    fetch_queue_if #(.XLEN(32)) dq  ();
    fetch_queue_if #(.XLEN(32)) dqw ();

    always #10 clk = ~clk;

    fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .dec            (dq),
        .count          (count)
    );

    fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk            (clk),
        .rst_n          (rst_w),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .imem_req_valid (wreq),
        .imem_addr      (waddr),
        .imem_rdata     (wrdata),
        .dec            (dqw),
        .count          (wcount)
    );

    // Instruction memories: word at byte address a holds a>>2, returned one cycle later.
    always @(posedge clk) if (imem_req_valid) imem_rdata <= imem_addr >> 2;
    always @(posedge clk) if (wreq) wrdata <= waddr >> 2;

    // Reference model state
    fetch_entry_t m_q[$];
    logic         m_pend;
    logic [31:0]  m_pend_pc;
    logic [31:0]  m_pc;

    int n_cmp;
    int n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pend    = 1'b0;
        m_pend_pc = '0;
        m_pc      = 32'h0;
    endtask

    // One clock cycle: drive inputs after the falling edge, check outputs, advance the model.
    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
        logic         exp_req;
        fetch_entry_t e;
        @(negedge clk);
        redirect_valid = rv;
        redirect_pc    = rpc;
        dq.ready       = rdy;
        #1;
        exp_req = !rv && ((m_q.size() + int'(m_pend)) < DEPTH);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr, m_pc);
        chk("count", 32'(count), 32'(m_q.size()));
        chk("out_valid", 32'(dq.valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk("out_pc", dq.pc, m_q[0].pc);
            chk("out_instr", dq.instr, m_q[0].instr);
        end
        if (rv) begin
            m_q.delete();
            m_pend = 1'b0;
            m_pc   = rpc & ~32'h3;
        end else begin
            if (rdy && m_q.size() > 0) void'(m_q.pop_front());
            if (m_pend) begin
                e.pc    = m_pend_pc;
                e.instr = m_pend_pc >> 2;
                m_q.push_back(e);
            end
            m_pend = exp_req;
            if (exp_req) begin
                m_pend_pc = m_pc;
                m_pc      = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int maxc;
        int nreq;
        int gap;
        int maxgap;
        logic rv;
        logic rdy;
        logic [31:0] rpc;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        rst_w = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dq.ready  = 1'b1;
        dqw.ready = 1'b1;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_out_valid", 32'(dq.valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_pc", dq.pc, 32'd0);
        chk("rst_out_instr", dq.instr, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // 1: streaming from reset
        maxc = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 32'h0, 1'b1);
            if (int'(count) > maxc) maxc = int'(count);
            if (i == 0) chk("t1_first_addr", imem_addr, 32'h0);
            if (i == 2) chk("t1_first_out_pc", dq.pc, 32'h0);
        end
        chk("t1_max_count", 32'(maxc), 32'd1);

        // 2: back-pressure fills exactly DEPTH entries, then drains and resumes
        step(1'b1, 32'h0, 1'b1);
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 32'h0, 1'b0);
            nreq += int'(imem_req_valid);
        end
        chk("t2_requests", 32'(nreq), 32'd4);
        chk("t2_count_full", 32'(count), 32'd4);
        chk("t2_req_stalled", 32'(imem_req_valid), 32'd0);
        gap = 0;
        maxgap = 0;
        for (int j = 0; j < 12; j++) begin
            step(1'b0, 32'h0, 1'b1);
            if (j == 0) chk("t2_pop0", dq.pc, 32'h0);
            if (j == 3) chk("t2_pop12", dq.pc, 32'hC);
            if (j == 4) chk("t2_resume16", dq.pc, 32'h10);
            gap = dq.valid ? 0 : gap + 1;
            if (gap > maxgap) maxgap = gap;
        end
        chk("t2_max_gap_le2", 32'(maxgap <= 2), 32'd1);

        // 3: redirect while 3 entries queued and one request in flight
        for (int k = 0; k < 10 && !(m_q.size() == 3 && m_pend); k++) step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h64, 1'b1);
        chk("t3_redirect_cycle_no_req", 32'(imem_req_valid), 32'd0);
        step(1'b0, 32'h0, 1'b1);
        chk("t3_count_flushed", 32'(count), 32'd0);
        chk("t3_req_after", 32'(imem_req_valid), 32'd1);
        chk("t3_addr_after", imem_addr, 32'h64);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        chk("t3_out_valid_t3", 32'(dq.valid), 32'd1);
        chk("t3_out_pc_t3", dq.pc, 32'h64);
        for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 1'b1);

        // 4: misaligned redirect, then back-to-back redirects
        step(1'b1, 32'h66, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        chk("t4_aligned_addr", imem_addr, 32'h64);
        for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h20, 1'b1);
        step(1'b1, 32'h40, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        chk("t4_last_wins_addr", imem_addr, 32'h40);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        chk("t4_last_wins_pc", dq.pc, 32'h40);
        for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 1'b1);

        // 5: PC wrap on the second instance
        @(posedge clk);
        #2 rst_w = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 32'h0, 1'b1);
            if (k == 0) chk("t5_addr0", waddr, 32'hFFFF_FFF8);
            if (k == 1) chk("t5_addr1", waddr, 32'hFFFF_FFFC);
            if (k == 2) chk("t5_addr2", waddr, 32'h0000_0000);
            if (k == 2) chk("t5_out_pc0", dqw.pc, 32'hFFFF_FFF8);
            if (k == 3) chk("t5_out_pc1", dqw.pc, 32'hFFFF_FFFC);
            if (k == 4) chk("t5_out_pc2", dqw.pc, 32'h0000_0000);
            if (k == 4) chk("t5_out_instr2", dqw.instr, 32'h0000_0000);
            if (k == 4) chk("t5_count", 32'(wcount), 32'd1);
            chk("t5_req", 32'(wreq), 32'd1);
        end

        // Random phase
        for (int k = 0; k < 300; k++) begin
            rv  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rpc = $urandom;
            step(rv, rpc, rdy);
        end
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);

        // 6: asynchronous reset between edges
        #3 rst_n = 1'b0;
        #1;
        chk("t6_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t6_out_valid", 32'(dq.valid), 32'd0);
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_out_pc", dq.pc, 32'd0);
        chk("t6_out_instr", dq.instr, 32'd0);
        chk("t6_addr", imem_addr, 32'd0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 32'h0, 1'b1);
            if (k == 0) chk("t6_restart_addr", imem_addr, 32'h0);
            if (k == 2) chk("t6_restart_pc", dq.pc, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
